// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// The CPU writes VALUE/CTRL into shadow registers; they are copied into the
// active registers only on the last cycle of a frame, so the display never
// shows a half-updated value. Each digit slot lasts SCAN_DIV cycles: the
// first cycle is blanked to suppress ghosting, the rest drive the digit.
//
// Write port: wr_en is a single-cycle strobe with no back-pressure. Every
// cycle in which wr_en is high loads wr_data into the shadow register chosen
// by wr_addr (0 = VALUE, 1 = CTRL). The write is always accepted.
//
// The display outputs are registered from the next-state values, so AN and
// Segment always describe the same cycle as the digit index and slot counter.
module seg7_scan_ctrl #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic        wr_addr,
    input  logic [15:0] wr_data,
    output logic [7:0]  Segment,
    output logic [3:0]  AN,
    output logic        frame_tick,
    output logic        pending
);

    localparam int              CNT_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [8:0]      CTRL_RST = 9'h100;

    generate
        if (SCAN_DIV < 2) begin : g_bad_scan_div
            $error("seg7_scan_ctrl: SCAN_DIV must be at least 2");
        end
    endgenerate

    // Active-low gfedcba pattern for one hex nibble.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    // Register state
    logic [15:0]      shadow_value, active_value;
    logic [8:0]       shadow_ctrl,  active_ctrl;
    logic [1:0]       d;
    logic [CNT_W-1:0] cnt;

    // Next-state values
    logic             slot_end;
    logic             commit;
    logic [1:0]       d_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [15:0]      shadow_value_nxt, active_value_nxt;
    logic [8:0]       shadow_ctrl_nxt,  active_ctrl_nxt;
    logic             pending_nxt;

    // Display decode of the next state
    logic [3:0]       nibble_nxt;
    logic [3:0]       dp_nxt;
    logic [3:0]       blank_nxt;
    logic             lit_nxt;
    logic [3:0]       an_nxt;
    logic [7:0]       seg_nxt;

    assign slot_end = (cnt == CNT_LAST);
    assign commit   = slot_end && (d == 2'd3);
    assign cnt_nxt  = slot_end ? '0 : cnt + CNT_W'(1);
    assign d_nxt    = slot_end ? d + 2'd1 : d;

    // Shadow load, with a same-cycle write bypassed straight into the commit.
    always_comb begin
        shadow_value_nxt = shadow_value;
        shadow_ctrl_nxt  = shadow_ctrl;
        if (wr_en && !wr_addr) shadow_value_nxt = wr_data;
        if (wr_en &&  wr_addr) shadow_ctrl_nxt  = wr_data[8:0];
        active_value_nxt = commit ? shadow_value_nxt : active_value;
        active_ctrl_nxt  = commit ? shadow_ctrl_nxt  : active_ctrl;
        // A commit swallows any write, including one in the commit cycle.
        pending_nxt      = commit ? 1'b0 : (pending | wr_en);
    end

    // Pick the digit that will be on during the next cycle.
    always_comb begin
        nibble_nxt = active_value_nxt[{d_nxt, 2'b00} +: 4];
        dp_nxt     = active_ctrl_nxt[3:0];
        blank_nxt  = active_ctrl_nxt[7:4];
        lit_nxt    = (cnt_nxt != '0) && active_ctrl_nxt[8] && !blank_nxt[d_nxt];
        an_nxt     = 4'b1111;
        seg_nxt    = 8'hFF;
        if (lit_nxt) begin
            an_nxt  = ~(4'b0001 << d_nxt);
            seg_nxt = {~dp_nxt[d_nxt], hex_to_seg(nibble_nxt)};
        end
    end

    // Scan position: slot counter and digit index.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            d   <= 2'd0;
        end else begin
            cnt <= cnt_nxt;
            d   <= d_nxt;
        end
    end

    // Shadow and active register banks plus the pending flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_value <= 16'h0000;
            active_value <= 16'h0000;
            shadow_ctrl  <= CTRL_RST;
            active_ctrl  <= CTRL_RST;
            pending      <= 1'b0;
        end else begin
            shadow_value <= shadow_value_nxt;
            active_value <= active_value_nxt;
            shadow_ctrl  <= shadow_ctrl_nxt;
            active_ctrl  <= active_ctrl_nxt;
            pending      <= pending_nxt;
        end
    end

    // Registered display pins and frame pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            AN         <= 4'b1111;
            Segment    <= 8'hFF;
            frame_tick <= 1'b0;
        end else begin
            AN         <= an_nxt;
            Segment    <= seg_nxt;
            frame_tick <= commit;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl with SCAN_DIV = 4 (16-cycle frames).
module tb_seg7_scan_ctrl;

    localparam int SD    = 4;
    localparam int FRAME = 4 * SD;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wr_en = 1'b0;
    logic        wr_addr = 1'b0;
    logic [15:0] wr_data = 16'h0000;
    logic [7:0]  Segment;
    logic [3:0]  AN;
    logic        frame_tick;
    logic        pending;

    always #5 clk = ~clk;

    seg7_scan_ctrl #(.SCAN_DIV(SD)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .Segment    (Segment),
        .AN         (AN),
        .frame_tick (frame_tick),
        .pending    (pending)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Time since reset release, in cycles; digit and slot position follow by division.
    logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    int          m_t;
    logic [15:0] m_sh_val, m_act_val, m_sh_ctrl, m_act_ctrl;
    logic        m_pending, m_tick;
    logic [13:0] exp_q[$];

    function automatic logic [11:0] model_drive(input int t, input logic [15:0] val,
                                                input logic [15:0] ctrl);
        int pos, dig, nib;
        logic [3:0] an;
        pos = t % SD;
        dig = (t / SD) % 4;
        if (pos == 0 || ctrl[8] == 1'b0 || ctrl[4 + dig] == 1'b1) return {4'hF, 8'hFF};
        nib = int'((val >> (4 * dig)) & 16'h000F);
        an  = 4'(15 - (1 << dig));
        return {an, ~ctrl[dig], seg_tab[nib]};
    endfunction

    always @(posedge clk) begin
        logic commit;
        if (!reset) begin
            m_t = 0;
            m_sh_val = 16'h0000;  m_act_val  = 16'h0000;
            m_sh_ctrl = 16'h0100; m_act_ctrl = 16'h0100;
            m_pending = 1'b0;     m_tick     = 1'b0;
        end else begin
            commit = ((m_t % FRAME) == FRAME - 1);
            if (wr_en) begin
                if (wr_addr) m_sh_ctrl = wr_data;
                else         m_sh_val  = wr_data;
            end
            if (commit) begin
                m_act_val  = m_sh_val;
                m_act_ctrl = m_sh_ctrl;
                m_pending  = 1'b0;
            end else if (wr_en) begin
                m_pending = 1'b1;
            end
            m_tick = commit;
            m_t++;
        end
        exp_q.push_back({model_drive(m_t, m_act_val, m_act_ctrl), m_tick, m_pending});
    end

    // Scoreboard: one expected output word per clock, compared on the falling edge.
    always @(negedge clk) begin
        logic [13:0] exp;
        if (exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            check("model_outputs", {18'h0, AN, Segment, frame_tick, pending}, {18'h0, exp});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic write_reg(input logic addr, input logic [15:0] data);
        wr_addr = addr;
        wr_data = data;
        wr_en   = 1'b1;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b0;
        repeat (cycles) step();
        reset = 1'b1;
    endtask

    task automatic wait_tick();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            step();
            if (frame_tick) begin
                seen = 1'b1;
                break;
            end
        end
        check("frame_tick_seen", 32'(seen), 32'd1);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [15:0] value;
        logic [15:0] ctrl;
        int          digit;
        logic [3:0]  an;
        logic [7:0]  seg;
    } vec_t;

    vec_t vecs [12];

    logic [3:0] an_scan  [4];
    logic [7:0] seg_scan [4];

    initial begin
        int first_tick;
        int n_ticks;
        bit pend_held;
        int r;

        vecs[0]  = '{16'hA81F, 16'h0100, 0, 4'b1110, 8'h8E};
        vecs[1]  = '{16'hA81F, 16'h0100, 1, 4'b1101, 8'hF9};
        vecs[2]  = '{16'hA81F, 16'h0100, 2, 4'b1011, 8'h80};
        vecs[3]  = '{16'hA81F, 16'h0100, 3, 4'b0111, 8'h88};
        vecs[4]  = '{16'h0000, 16'h0125, 0, 4'b1110, 8'h40};
        vecs[5]  = '{16'h0000, 16'h0125, 1, 4'b1111, 8'hFF};
        vecs[6]  = '{16'h0000, 16'h0125, 2, 4'b1011, 8'h40};
        vecs[7]  = '{16'h0000, 16'h0125, 3, 4'b0111, 8'hC0};
        vecs[8]  = '{16'h0000, 16'h0000, 0, 4'b1111, 8'hFF};
        vecs[9]  = '{16'h1234, 16'h0100, 0, 4'b1110, 8'h99};
        vecs[10] = '{16'h1234, 16'h0100, 3, 4'b0111, 8'hF9};
        vecs[11] = '{16'h0C9D, 16'h010F, 1, 4'b1101, 8'h10};

        an_scan  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        seg_scan = '{8'h8E, 8'hF9, 8'h80, 8'h88};

        // Reset: outputs dark while held.
        step();
        check("reset_an", 32'(AN), 32'hF);
        check("reset_seg", 32'(Segment), 32'hFF);
        check("reset_pending", 32'(pending), 32'd0);
        repeat (4) step();
        reset = 1'b1;                      // t = 0 (blank slot)
        check("release_t0_an", 32'(AN), 32'hF);
        for (int t = 1; t <= 3; t++) begin
            step();
            check("release_an", 32'(AN), 32'hE);
            check("release_seg", 32'(Segment), 32'hC0);
        end
        first_tick = -1;
        for (int t = 4; t <= 3 * FRAME; t++) begin
            step();
            if (frame_tick) begin
                first_tick = t;
                break;
            end
        end
        check("first_tick_cycle", 32'(first_tick), 32'd16);

        // Mid-frame VALUE write held pending until the commit.
        repeat (4) step();                 // t = 20
        write_reg(1'b0, 16'hA81F);         // t = 21
        check("pending_rise", 32'(pending), 32'd1);
        pend_held = 1'b1;
        for (int i = 0; i < 3 * FRAME; i++) begin
            step();
            if (frame_tick) break;
            if (pending !== 1'b1) pend_held = 1'b0;
        end
        check("pending_held", 32'(pend_held), 32'd1);
        check("tick_at_32", 32'(frame_tick), 32'd1);
        check("pending_fall", 32'(pending), 32'd0);
        for (int k = 0; k < FRAME; k++) begin
            if (k > 0) step();
            if (k % SD == 0) begin
                check("scan_blank_an", 32'(AN), 32'hF);
            end else begin
                check("scan_an", 32'(AN), 32'(an_scan[k / SD]));
                check("scan_seg", 32'(Segment), 32'(seg_scan[k / SD]));
            end
        end

        // VALUE write in the commit cycle (t = 47) bypasses straight to active.
        write_reg(1'b0, 16'h1234);         // t = 48
        check("bypass_pending", 32'(pending), 32'd0);
        check("bypass_tick", 32'(frame_tick), 32'd1);
        step();                            // t = 49
        check("bypass_an", 32'(AN), 32'hE);
        check("bypass_seg", 32'(Segment), 32'h99);

        // Display disabled: dark for a whole frame, ticks keep coming.
        write_reg(1'b1, 16'h0000);
        wait_tick();                       // t = 64
        check("off_an", 32'(AN), 32'hF);
        n_ticks = 0;
        for (int k = 1; k <= FRAME; k++) begin
            step();
            check("off_an", 32'(AN), 32'hF);
            check("off_seg", 32'(Segment), 32'hFF);
            if (k < FRAME && frame_tick) n_ticks++;
        end
        check("off_tick_period", 32'(frame_tick), 32'd1);
        check("off_no_extra_tick", 32'(n_ticks), 32'd0);

        // Reset before commit discards the pending VALUE write.
        write_reg(1'b1, 16'h0100);
        write_reg(1'b0, 16'h8888);
        check("pre_reset_pending", 32'(pending), 32'd1);
        reset = 1'b0;
        #1;
        check("async_reset_an", 32'(AN), 32'hF);
        check("async_reset_seg", 32'(Segment), 32'hFF);
        check("async_reset_pending", 32'(pending), 32'd0);
        repeat (2) step();
        reset = 1'b1;
        step();
        check("discard_an", 32'(AN), 32'hE);
        check("discard_seg", 32'(Segment), 32'hC0);
        check("discard_pending", 32'(pending), 32'd0);

        // Table of committed register contents versus one lit cycle per digit.
        foreach (vecs[i]) begin
            do_reset(2);
            write_reg(1'b0, vecs[i].value);
            write_reg(1'b1, vecs[i].ctrl);
            wait_tick();
            repeat (vecs[i].digit * SD + 2) step();
            check($sformatf("vec%0d_an", i), 32'(AN), 32'(vecs[i].an));
            check($sformatf("vec%0d_seg", i), 32'(Segment), 32'(vecs[i].seg));
        end

        // Random traffic against the model, with occasional resets.
        do_reset(2);
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 99);
            if (r == 0) begin
                do_reset($urandom_range(1, 3));
            end else if (r < 35) begin
                write_reg(1'($urandom_range(0, 1)), 16'($urandom));
            end else begin
                step();
            end
        end
        repeat (2) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexing controller for the board's 4-digit seven-segment display (`Segment`/`AN` at `Top`). It holds a CPU-written 16-bit hex value and a control word in shadow registers. It commits them to active registers only at frame boundaries, so a half-updated value never shows. It then scans the four digits round-robin with a programmable dwell and an anti-ghost blank slot.

## Interface

Parameters:
- `SCAN_DIV`, default 50000: clock cycles per digit slot. Legal range is ≥ 2; an illegal value is a elaboration-time error.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  single-cycle write strobe from the CPU bus.
- `wr_addr`  in  1  register select:
  - 0 = VALUE register.
  - 1 = CTRL register.
- `wr_data`  in  16  write data:
  - VALUE: four hex nibbles; digit0 = [3:0].
  - CTRL: [3:0] decimal point per digit, [7:4] blank per digit, [8] display enable, [15:9] ignored.
- `Segment`  out  8  registered, active-low. [7] = dp; [6:0] = g,f,e,d,c,b,a.
- `AN`  out  4  registered, active-low digit enables; AN[0] = rightmost digit (digit0).
- `frame_tick`  out  1  registered, one-cycle pulse on each commit cycle.
- `pending`  out  1  registered; high while a shadow register holds an uncommitted write.

## Operation

- Registers:
  - shadow VALUE/CTRL and active VALUE/CTRL.
  - digit index `d` (2 bits).
  - slot counter `cnt` (0..SCAN_DIV-1, width clog2(SCAN_DIV)).
  - `pending` flag.
- Reset state:
  - shadow and active VALUE = 0x0000; shadow and active CTRL = 0x0100 (enabled, no dp, no blank).
  - `d` = 0, `cnt` = 0, `pending` = 0, `frame_tick` = 0.
  - `AN` = 4'b1111, `Segment` = 8'hFF.
- Counter:
  - `cnt` increments every cycle.
  - At `cnt` = SCAN_DIV-1, `cnt` goes to 0 and `d` goes to (d+1) mod 4.
- Commit cycle: the cycle with `d` = 3 and `cnt` = SCAN_DIV-1. In it:
  - active ← shadow.
  - `frame_tick` = 1 in the following cycle.
  - `pending` clears.
- Write: when `wr_en` is high, the shadow register selected by `wr_addr` is loaded and `pending` sets next cycle.
- Simultaneous write and commit: the write is bypassed into the commit. The active register takes `wr_data` and `pending` ends at 0.
- Writes to the same register in consecutive cycles: last write wins.
- Display drive (a function of `d`, `cnt`, active regs, registered so it appears in the same cycle as that state):
  - AN is 4'b1111 and Segment is 8'hFF if any of these hold: `cnt` = 0 (anti-ghost slot), active CTRL[8] = 0, or active blank[d] = 1.
  - Otherwise AN = ~(4'b0001 << d), Segment[6:0] = hex decode of active nibble d, and Segment[7] = ~dp[d].
- Hex decode, active-low gfedcba:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78.
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.

## Timing

- Slot length is SCAN_DIV cycles: 1 cycle blanked, then SCAN_DIV-1 cycles lit. A frame is 4×SCAN_DIV cycles.
- Write-to-display latency:
  - Minimum 1 cycle: write in the commit cycle; visible from the next lit cycle.
  - Maximum 4×SCAN_DIV cycles.
- `pending` rises the cycle after a non-commit-cycle write and falls the cycle after commit.
- Reset assertion mid-frame:
  - All outputs go to reset values immediately (asynchronously); any uncommitted write is discarded.
  - After deassertion, scanning restarts at `d` = 0, `cnt` = 0.
- `frame_tick` period is exactly 4×SCAN_DIV cycles in steady state. The first pulse comes 4×SCAN_DIV cycles after reset release.

## Test plan

All scenarios use SCAN_DIV = 4.

1. Reset with `reset` = 0 for 5 cycles, then release.
   - During reset: AN = 1111, Segment = FF.
   - Release-cycle +1..+3: AN = 1110, Segment = C0 (digit0 = 0).
   - `frame_tick` first pulses at cycle 16.
2. Write VALUE = 0xA81F mid-frame.
   - `pending` = 1 until the commit.
   - Next frame slots show, in order: AN 1110 Seg 8E, AN 1101 Seg F9, AN 1011 Seg 80, AN 0111 Seg 88.
   - The cnt = 0 cycle of each slot shows AN = 1111.
3. Write CTRL = 0x0125 (enable, dp0 and dp2, blank digit1) with VALUE = 0x0000, then commit.
   - Digit0 Seg = 40.
   - Digit1 slot AN = 1111.
   - Digit2 Seg = 40.
   - Digit3 Seg = C0.
4. Write VALUE = 0x1234 exactly in the commit cycle.
   - `pending` stays 0.
   - Next slot shows digit0 Seg = 99 (value 4).
5. Write CTRL = 0x0000, then after commit: AN = 1111 and Segment = FF for a whole frame; `frame_tick` still pulses every 16 cycles.
6. Write VALUE = 0x8888, then assert reset before commit.
   - Outputs go off immediately.
   - After release, digit0 shows C0 (write discarded) and `pending` = 0.
